// File: rtl/fc_layer_sequencer.sv
// ----------------------------------------------------------------------------
// fc_layer_sequencer
//
// Frame controller for one fully-connected input layer. A frame reads
// INPUT_SIZE samples from an external sample memory (1-cycle read latency),
// streams them to the layer as exactly INPUT_SIZE gap-free beats, waits for
// the layer's result strobe, captures the result vector and offers it on a
// valid/ready port. Abort and timeout both route through FLUSH, which holds
// the layer's reset low for two cycles so its weight-address counter starts
// the next frame aligned.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    frame request (IDLE only) / cancel current frame
//   busy, done, err state != IDLE / 1-cycle result-handshake pulse / sticky timeout
//   frame_cnt       completed frames, wraps
//   mem_rd_en, mem_addr, mem_rdata   sample memory read port
//   fc_rst_n, fc_valid_in, fc_data   layer reset and sample stream
//   fc_valid_out, fc_out             layer result strobe and results
//   res_valid, res_ready, res_out    captured result port
// ----------------------------------------------------------------------------
module fc_layer_sequencer #(
    parameter int NUM_NUERONS    = 8,
    parameter int INPUT_SIZE     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [FRAME_CNT_W-1:0]               frame_cnt,
    output logic                                 mem_rd_en,
    output logic [$clog2(INPUT_SIZE)-1:0]        mem_addr,
    input  logic signed [DATA_WIDTH-1:0]         mem_rdata,
    output logic                                 fc_rst_n,
    output logic                                 fc_valid_in,
    output logic signed [DATA_WIDTH-1:0]         fc_data,
    input  logic                                 fc_valid_out,
    input  logic [NUM_NUERONS*ACC_WIDTH-1:0]     fc_out,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [NUM_NUERONS*ACC_WIDTH-1:0]     res_out
);

    localparam int ADDR_W = $clog2(INPUT_SIZE);
    // Counter holds 0..TIMEOUT_CYCLES-1; the +1 keeps the width >= 1.
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(INPUT_SIZE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STREAM = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   flush_q, flush_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   res_valid_q, res_valid_d;
    logic                   fc_rst_n_q, fc_rst_n_d;
    logic                   fc_valid_in_q, fc_valid_in_d;
    logic                   busy_q, busy_d;
    logic                   capture;
    logic                   kill_beat;

    always_comb begin
        state_d     = state_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_addr_d  = mem_addr_q;
        tmo_d       = tmo_q;
        flush_d     = flush_q;
        err_d       = err_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        res_valid_d = res_valid_q;
        fc_rst_n_d  = 1'b1;
        capture     = 1'b0;
        kill_beat   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    err_d   = 1'b0;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_d     = S_FLUSH;
                    mem_rd_en_d = 1'b0;
                    kill_beat   = 1'b1;
                    flush_d     = 1'b0;
                    fc_rst_n_d  = 1'b0;
                end else if (!mem_rd_en_q) begin
                    // First STREAM cycle: open the read window at address 0.
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = '0;
                end else if (mem_addr_q == ADDR_LAST) begin
                    mem_rd_en_d = 1'b0;
                    tmo_d       = '0;
                    state_d     = S_WAIT;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d    = S_FLUSH;
                    kill_beat  = 1'b1;
                    flush_d    = 1'b0;
                    fc_rst_n_d = 1'b0;
                end else if (fc_valid_out) begin
                    // Checked before the timeout so a same-cycle result wins.
                    capture     = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    err_d      = 1'b1;
                    flush_d    = 1'b0;
                    fc_rst_n_d = 1'b0;
                    state_d    = S_FLUSH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_HOLD: begin
                if (abort) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            S_FLUSH: begin
                // Entry already drove fc_rst_n low for one cycle; hold one more.
                if (flush_q) begin
                    state_d = S_IDLE;
                end else begin
                    flush_d    = 1'b1;
                    fc_rst_n_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mem_rd_en_d = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase

        busy_d        = (state_d != S_IDLE);
        // Beat follows the read strobe by the memory latency; an abort
        // cancels the read whose data would otherwise arrive next cycle.
        fc_valid_in_d = mem_rd_en_q & ~kill_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            tmo_q         <= '0;
            flush_q       <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            frame_cnt_q   <= '0;
            res_valid_q   <= 1'b0;
            fc_rst_n_q    <= 1'b0;
            fc_valid_in_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            tmo_q         <= tmo_d;
            flush_q       <= flush_d;
            err_q         <= err_d;
            done_q        <= done_d;
            frame_cnt_q   <= frame_cnt_d;
            res_valid_q   <= res_valid_d;
            fc_rst_n_q    <= fc_rst_n_d;
            fc_valid_in_q <= fc_valid_in_d;
            busy_q        <= busy_d;
        end
    end

    // One capture register per neuron lane.
    generate
        for (genvar gi = 0; gi < NUM_NUERONS; gi++) begin : g_lane
            logic [ACC_WIDTH-1:0] lane_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= '0;
                end else if (capture) begin
                    lane_q <= fc_out[gi*ACC_WIDTH +: ACC_WIDTH];
                end
            end
            assign res_out[gi*ACC_WIDTH +: ACC_WIDTH] = lane_q;
        end
    endgenerate

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign frame_cnt   = frame_cnt_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign fc_rst_n    = fc_rst_n_q;
    assign fc_valid_in = fc_valid_in_q;
    assign fc_data     = mem_rdata;
    assign res_valid   = res_valid_q;

endmodule
